user_obi_mailbox: RTL and testbench

- OBI subordinate for the user domain, occupying one 4 KiB window at UserBaseAddr (32'h2000_0000). It is the responder end of the user-domain demux's first subordinate rule.
- A core writes 32-bit words into a FIFO and reads them back in order. Status and control registers sit alongside the FIFO.
- Unmapped offsets and illegal accesses get an OBI error response.

---
 rtl/user_obi_mailbox.sv | 214 +++++++++++++++++++++
 tb/tb_user_obi_mailbox.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : user_obi_mailbox
//  Purpose  : OBI subordinate for the user domain (4 KiB window). Holds a
//             word FIFO that a core pushes and pops through DATA, with STATUS
//             and CTRL registers beside it. Unmapped or illegal accesses get
//             an error response with zero read data.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk_i         clock
//    rst_i         asynchronous, active-high reset
//    obi_req_i     request valid (always granted)
//    obi_gnt_o     grant, tied high
//    obi_addr_i    byte address, only [11:2] decoded
//    obi_we_i      1 = write
//    obi_be_i      byte enables
//    obi_wdata_i   write data
//    obi_aid_i     request ID
//    obi_rvalid_o  response valid, one cycle after the handshake
//    obi_rdata_o   response data
//    obi_err_o     response error
//    obi_rid_o     response ID (echo of aid)
//    irq_o         mailbox interrupt
//
//  Register map (word offset addr[11:2])
//    0x000 DATA    write pushes (full be required), read pops
//    0x004 STATUS  {count @ [8+:CntWidth], ovf, full, empty}, read-only
//    0x008 CTRL    bit0 FLUSH (W1, reads 0), bit1 IRQ_EN, bit2 OVF_CLR (W1)
//
//  Build option
//    USER_MBOX_IRQ_EN  defined: irq_o = IRQ_EN & (~empty | overflow),
//                      registered. Undefined: irq_o = 0, IRQ_EN reads 0.
// ============================================================================
module user_obi_mailbox #(
  parameter int Depth     = 8,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [31:0]            obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DataWidth/8-1:0] obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  input  logic [IdWidth-1:0]     obi_aid_i,
  output logic                   obi_rvalid_o,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic                   obi_err_o,
  output logic [IdWidth-1:0]     obi_rid_o,
  output logic                   irq_o
);

  localparam int CntWidth = $clog2(Depth + 1);
  localparam int PtrWidth = $clog2(Depth);
  localparam logic [CntWidth-1:0] DEPTH_CNT = CntWidth'(Depth);
  localparam logic [9:0] OFF_DATA   = 10'd0;
  localparam logic [9:0] OFF_STATUS = 10'd1;
  localparam logic [9:0] OFF_CTRL   = 10'd2;

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [CntWidth-1:0]  count;
  logic                 ovf_sticky;
  logic                 irq_en;
  logic                 empty;
  logic                 full;

  logic                 do_push;
  logic                 do_pop;
  logic                 do_flush;
  logic                 set_ovf;
  logic                 clr_ovf;
  logic                 irq_en_we;
  logic                 rsp_err;
  logic [DataWidth-1:0] rsp_rdata;
  logic [DataWidth-1:0] status_word;
  logic [DataWidth-1:0] ctrl_word;
  logic [9:0]           word_off;

  // The window decode lives in the upstream demux; sub-word address bits
  // carry no meaning for a word-only register block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_addr_i[31:12], obi_addr_i[1:0]};

  assign obi_gnt_o = 1'b1;
  assign word_off  = obi_addr_i[11:2];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);

  always_comb begin
    status_word                 = '0;
    status_word[0]              = empty;
    status_word[1]              = full;
    status_word[2]              = ovf_sticky;
    status_word[8 +: CntWidth]  = count;
    ctrl_word                   = '0;
    ctrl_word[1]                = irq_en;
  end

  // Access decode: every side effect below is qualified by the handshake and
  // commits at the same edge that captures the response.
  always_comb begin
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_flush  = 1'b0;
    set_ovf   = 1'b0;
    clr_ovf   = 1'b0;
    irq_en_we = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (obi_req_i) begin
      case (word_off)
        OFF_DATA: begin
          if (obi_we_i) begin
            // Any DATA write that meets a full FIFO marks the overflow.
            if (full) set_ovf = 1'b1;
            if (full || !(&obi_be_i)) rsp_err = 1'b1;
            else                      do_push = 1'b1;
          end else if (empty) begin
            rsp_err = 1'b1;
          end else begin
            rsp_rdata = mem[rd_ptr];
            do_pop    = 1'b1;
          end
        end
        OFF_STATUS: begin
          if (obi_we_i) rsp_err   = 1'b1;
          else          rsp_rdata = status_word;
        end
        OFF_CTRL: begin
          if (obi_we_i) begin
            do_flush  = obi_wdata_i[0];
            clr_ovf   = obi_wdata_i[2];
            irq_en_we = 1'b1;
          end else begin
            rsp_rdata = ctrl_word;
          end
        end
        default: rsp_err = 1'b1;
      endcase
    end
  end

  // FIFO bookkeeping; push and pop are mutually exclusive (one access/cycle).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (do_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (do_push) begin
        wr_ptr <= wr_ptr + PtrWidth'(1);
        count  <= count + CntWidth'(1);
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + PtrWidth'(1);
        count  <= count - CntWidth'(1);
      end
      if (set_ovf)      ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
    end
  end

  // Storage carries no reset; contents are meaningless once pointers reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= obi_wdata_i;
  end

  // Response registers; the async reset drops a pending response at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_err_o    <= 1'b0;
      obi_rid_o    <= '0;
    end else begin
      obi_rvalid_o <= obi_req_i;
      if (obi_req_i) begin
        obi_rdata_o <= rsp_rdata;
        obi_err_o   <= rsp_err;
        obi_rid_o   <= obi_aid_i;
      end
    end
  end

`ifdef USER_MBOX_IRQ_EN
  // irq_o samples the state that the previous edge produced, so it follows
  // the causing access by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (irq_en_we) irq_en <= obi_wdata_i[1];
      irq_o <= irq_en & (~empty | ovf_sticky);
    end
  end
`else
  logic unused_irq_we;
  assign unused_irq_we = irq_en_we;
  assign irq_en        = 1'b0;
  assign irq_o         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_user_obi_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_user_obi_mailbox
//  Purpose  : Self-checking bench for user_obi_mailbox: a vector table for
//             single accesses plus sequences for overflow, flush, pointer
//             wrap, back-to-back handshakes and reset during a response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_user_obi_mailbox;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [0:0]  aid = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [0:0]  rid;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  user_obi_mailbox dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (req),
    .obi_gnt_o    (gnt),
    .obi_addr_i   (addr),
    .obi_we_i     (we),
    .obi_be_i     (be),
    .obi_wdata_i  (wdata),
    .obi_aid_i    (aid),
    .obi_rvalid_o (rvalid),
    .obi_rdata_o  (rdata),
    .obi_err_o    (err),
    .obi_rid_o    (rid),
    .irq_o        (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] model_q[$];

`ifdef USER_MBOX_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h0000_0002;
`else
  localparam logic [31:0] CTRL_RB = 32'h0000_0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One handshake; the response is checked #1 after the capturing edge.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_e, input string name);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    check({name, " rvalid"}, {31'd0, rvalid}, 32'd1);
    check({name, " err"}, {31'd0, err}, {31'd0, exp_e});
    if (!w || exp_e) check({name, " rdata"}, rdata, exp_rd);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic ee, input string n);
    vec_t v;
    v.we = w; v.addr = a; v.be = b; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.name = n;
    return v;
  endfunction

  initial begin
    logic [31:0] nxt;
    logic [31:0] exp_word;
    nxt = 32'hC000_0000;

    vecs.push_back(mk(1, 32'h2000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, "push1"));
    vecs.push_back(mk(1, 32'h2000_0000, 4'hF, 32'h1234_5678, 32'h0, 0, "push2"));
    vecs.push_back(mk(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0200, 0, "status_cnt2"));
    vecs.push_back(mk(0, 32'h2000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, "pop1"));
    vecs.push_back(mk(0, 32'h2000_0000, 4'hF, 32'h0, 32'h1234_5678, 0, "pop2"));
    vecs.push_back(mk(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_empty"));
    vecs.push_back(mk(0, 32'h2000_0000, 4'hF, 32'h0, 32'h0, 1, "pop_empty"));
    vecs.push_back(mk(0, 32'h2000_000C, 4'hF, 32'h0, 32'h0, 1, "rd_unmapped"));
    vecs.push_back(mk(1, 32'h2000_0000, 4'h3, 32'h5555_AAAA, 32'h0, 1, "push_partial_be"));
    vecs.push_back(mk(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_after_partial"));
    vecs.push_back(mk(1, 32'h2000_0004, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, "wr_status"));
    vecs.push_back(mk(1, 32'h2000_0FFC, 4'hF, 32'h1, 32'h0, 1, "wr_unmapped"));
    vecs.push_back(mk(1, 32'h2000_0008, 4'h0, 32'h0000_0002, 32'h0, 0, "wr_ctrl_irqen"));
    vecs.push_back(mk(0, 32'h2000_0008, 4'hF, 32'h0, CTRL_RB, 0, "rd_ctrl"));
    vecs.push_back(mk(1, 32'h2000_0008, 4'hF, 32'h0, 32'h0, 0, "wr_ctrl_zero"));
    vecs.push_back(mk(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_unchanged"));

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rid", {31'd0, rid}, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    check("gnt tied", {31'd0, gnt}, 32'd1);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i])
      access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);

    // Fill past full: the ninth word is refused and flags overflow
    for (int i = 0; i < 9; i++)
      access(1, 32'h2000_0000, 4'hF, 32'hA000_0000 + i, 32'h0, (i == 8), "fill");
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0806, 0, "status_full_ovf");
    access(1, 32'h2000_0008, 4'hF, 32'h4, 32'h0, 0, "ovf_clr");
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0802, 0, "status_full");
    for (int i = 0; i < 5; i++)
      access(0, 32'h2000_0000, 4'hF, 32'h0, 32'hA000_0000 + i, 0, "drain_part");
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0300, 0, "status_cnt3");
    access(1, 32'h2000_0008, 4'hF, 32'h1, 32'h0, 0, "flush");
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_flushed");
    access(0, 32'h2000_0008, 4'hF, 32'h0, 32'h0, 0, "ctrl_after_flush");

    // Pointer wrap: 16 pushes, 16 pops, order checked against a queue model
    for (int r = 0; r < 8; r++) begin
      access(1, 32'h2000_0000, 4'hF, nxt, 32'h0, 0, "wrap_push");
      model_q.push_back(nxt); nxt++;
      exp_word = model_q.pop_front();
      access(0, 32'h2000_0000, 4'hF, 32'h0, exp_word, 0, "wrap_pop");
    end
    for (int r = 0; r < 8; r++) begin
      access(1, 32'h2000_0000, 4'hF, nxt, 32'h0, 0, "wrap_fill");
      model_q.push_back(nxt); nxt++;
    end
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0802, 0, "status_wrap_full");
    while (model_q.size() > 0) begin
      exp_word = model_q.pop_front();
      access(0, 32'h2000_0000, 4'hF, 32'h0, exp_word, 0, "wrap_drain");
    end
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_wrap_empty");

    // Back-to-back handshakes with alternating IDs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h2000_0004; be = 4'hF; aid = 1'(i % 2);
      @(posedge clk);
      #1;
      check("b2b rvalid", {31'd0, rvalid}, 32'd1);
      check("b2b rid", {31'd0, rid}, 32'(i % 2));
      check("b2b rdata", rdata, 32'h0000_0001);
    end
    @(negedge clk) req = 1'b0;
    @(posedge clk);
    #1 check("b2b rvalid drop", {31'd0, rvalid}, 32'd0);

    // Reset while a read response is pending
    access(1, 32'h2000_0000, 4'hF, 32'h7777_0001, 32'h0, 0, "pre_rst_push");
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h2000_0000; be = 4'hF; aid = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    check("pending rvalid", {31'd0, rvalid}, 32'd1);
    check("pending rdata", rdata, 32'h7777_0001);
    #1 rst = 1'b1;
    #1;
    check("rst async rvalid", {31'd0, rvalid}, 32'd0);
    check("rst rid", {31'd0, rid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    access(0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0001, 0, "status_after_rst");

`ifdef USER_MBOX_IRQ_EN
    access(1, 32'h2000_0008, 4'hF, 32'h2, 32'h0, 0, "irq_enable");
    access(1, 32'h2000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 0, "irq_push");
    check("irq same cycle", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 check("irq raised", {31'd0, irq}, 32'd1);
    access(0, 32'h2000_0000, 4'hF, 32'h0, 32'h0BAD_F00D, 0, "irq_pop");
    @(posedge clk);
    #1 check("irq cleared", {31'd0, irq}, 32'd0);
`else
    access(1, 32'h2000_0008, 4'hF, 32'h2, 32'h0, 0, "irq_en_ignored");
    access(1, 32'h2000_0000, 4'hF, 32'h0BAD_F00D, 32'h0, 0, "irq_push");
    @(posedge clk);
    #1 check("irq tied low", {31'd0, irq}, 32'd0);
    access(0, 32'h2000_0008, 4'hF, 32'h0, 32'h0, 0, "ctrl_irqen_reads0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
